uart_rx_framed: RTL and testbench

Parametrised UART receiver that generalises the fixed 8N1 receiver. It supports 5–9 data bits, none/even/odd parity and one or two stop bits. It adds an input synchroniser, false-start rejection, and parity and framing error reporting. Received words leave on an AXI-stream-style interface with error flags in `tuser`. The block sits between the serial pin and the byte-stream consumer; the companion transmitter uses the same package.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx_framed.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver and the companion transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_t;

   localparam int unsigned TUSER_PARITY_ERR = 0;
   localparam int unsigned TUSER_FRAME_ERR  = 1;
   localparam int unsigned TUSER_W          = 2;

   // xor_all is the XOR of every data bit and the received parity bit.
   function automatic logic parity_error(input parity_t mode, input logic xor_all);
      case (mode)
         PARITY_EVEN: return xor_all;
         PARITY_ODD:  return ~xor_all;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_framed.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits) with
// false-start rejection, error flags and a single-entry AXI-stream style output.
module uart_rx_framed
   import uart_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BIT = 434,
   parameter int unsigned DATA_BITS      = 8,
   parameter parity_t     PARITY         = PARITY_NONE,
   parameter int unsigned STOP_BITS      = 1,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 tready,
   output logic                 tvalid,
   output logic [DATA_BITS-1:0] tdata,
   output logic [1:0]           tuser,
   output logic                 overflow
);

   localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   logic rxs;

   rx_state_t            state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic [DATA_BITS-1:0] shreg_q,   shreg_d;
   logic                 perr_q,    perr_d;
   logic                 ferr_q,    ferr_d;
   logic                 tvalid_q,  tvalid_d;
   logic [DATA_BITS-1:0] tdata_q,   tdata_d;
   logic [TUSER_W-1:0]   tuser_q,   tuser_d;
   logic                 overflow_q, overflow_d;
   logic                 done_c;
   logic                 bit_end_c;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rxs)
   );

   assign bit_end_c = (cnt_q == BIT_LAST);

   // Frame FSM: every sample point after the start bit is one full bit period apart.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rxs) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_PARITY: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               perr_d  = parity_error(PARITY, (^shreg_q) ^ rxs);
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_STOP: begin
            if (bit_end_c) begin
               cnt_d  = '0;
               ferr_d = ferr_q | ~rxs;
               if (idx_q == STOP_LAST) begin
                  idx_d   = '0;
                  done_c  = 1'b1;
                  state_d = ferr_d ? ST_WAIT_HIGH : ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // A held-low line (break) must not be mistaken for a new start bit.
         ST_WAIT_HIGH: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Output register: a completing word always wins over a pending handshake.
   always_comb begin
      tvalid_d   = tvalid_q & ~tready;
      tdata_d    = tdata_q;
      tuser_d    = tuser_q;
      overflow_d = 1'b0;

      if (done_c) begin
         tvalid_d                  = 1'b1;
         tdata_d                   = shreg_q;
         tuser_d[TUSER_PARITY_ERR] = perr_q;
         tuser_d[TUSER_FRAME_ERR]  = ferr_d;
         overflow_d                = tvalid_q & ~tready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tuser_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tuser_q    <= tuser_d;
         overflow_q <= overflow_d;
      end
   end

   assign tvalid   = tvalid_q;
   assign tdata    = tdata_q;
   assign tuser    = tuser_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench: four receiver configurations driven by a bit-level line model.
module tb_uart_rx_framed;
   import uart_pkg::*;

   localparam int CPB  = 16;
   localparam int SYNC = 2;

   typedef struct {
      int         u;
      logic [8:0] data;
      logic [1:0] user;
      int         cyc;
   } beat_t;

   typedef struct {
      int         u;
      logic [8:0] data;
      logic       pbit;
      logic [1:0] stops;
      logic [8:0] exp_data;
      logic [1:0] exp_user;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rx_v;
   logic [3:0] tready_v;

   logic [7:0] td_a;
   logic [6:0] td_b;
   logic [7:0] td_c;
   logic [8:0] td_d;
   logic [1:0] tu_a, tu_b, tu_c, tu_d;
   logic       tv_a, tv_b, tv_c, tv_d;
   logic       ov_a, ov_b, ov_c, ov_d;

   logic [8:0] td_v [4];
   logic [1:0] tu_v [4];
   logic [3:0] tv_v;
   logic [3:0] ov_v;

   int      db_a  [4] = '{8, 7, 8, 9};
   parity_t par_a [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_NONE, PARITY_ODD};
   int      sb_a  [4] = '{1, 1, 2, 1};

   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   int    ov_cnt [4] = '{0, 0, 0, 0};
   beat_t beat_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_framed #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE),
                    .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .tready(tready_v[0]),
      .tvalid(tv_a), .tdata(td_a), .tuser(tu_a), .overflow(ov_a));

   uart_rx_framed #(.CYCLES_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_EVEN),
                    .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .tready(tready_v[1]),
      .tvalid(tv_b), .tdata(td_b), .tuser(tu_b), .overflow(ov_b));

   uart_rx_framed #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE),
                    .STOP_BITS(2), .SYNC_STAGES(SYNC)) u_c (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .tready(tready_v[2]),
      .tvalid(tv_c), .tdata(td_c), .tuser(tu_c), .overflow(ov_c));

   uart_rx_framed #(.CYCLES_PER_BIT(CPB), .DATA_BITS(9), .PARITY(PARITY_ODD),
                    .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_d (
      .clk(clk), .rst_n(rst_n), .rx(rx_v[3]), .tready(tready_v[3]),
      .tvalid(tv_d), .tdata(td_d), .tuser(tu_d), .overflow(ov_d));

   assign td_v[0] = 9'(td_a);
   assign td_v[1] = 9'(td_b);
   assign td_v[2] = 9'(td_c);
   assign td_v[3] = td_d;
   assign tu_v[0] = tu_a;
   assign tu_v[1] = tu_b;
   assign tu_v[2] = tu_c;
   assign tu_v[3] = tu_d;
   assign tv_v    = {tv_d, tv_c, tv_b, tv_a};
   assign ov_v    = {ov_d, ov_c, ov_b, ov_a};

   // Inputs change just after posedge, so the negedge view is what the next edge will see.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (tv_v[i] && tready_v[i]) beat_q.push_back('{i, td_v[i], tu_v[i], cyc});
         if (ov_v[i]) ov_cnt[i]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int lat_exp(input int u);
      int p;
      p = (par_a[u] != PARITY_NONE) ? 1 : 0;
      return SYNC + CPB / 2 + (db_a[u] + p + sb_a[u]) * CPB + 1;
   endfunction

   // Expected word from the framing rules: count ones for parity, any low stop bit is a frame error.
   task automatic model(input int u, input logic [8:0] data, input logic pbit,
                        input logic [1:0] stops, output logic [8:0] ed, output logic [1:0] eu);
      int ones;
      int mask;
      logic ferr;
      mask = (1 << db_a[u]) - 1;
      ed   = data & 9'(mask);
      ones = $countones(ed) + int'(pbit);
      ferr = 1'b0;
      for (int k = 0; k < sb_a[u]; k++) if (stops[k] == 1'b0) ferr = 1'b1;
      eu[TUSER_FRAME_ERR] = ferr;
      case (par_a[u])
         PARITY_EVEN: eu[TUSER_PARITY_ERR] = (ones % 2) == 1;
         PARITY_ODD:  eu[TUSER_PARITY_ERR] = (ones % 2) == 0;
         default:     eu[TUSER_PARITY_ERR] = 1'b0;
      endcase
   endtask

   task automatic drive_bit(input int u, input logic v);
      rx_v[u] = v;
      repeat (CPB) tick();
   endtask

   task automatic send_frame(input int u, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops, input logic end_level, output int fall_cyc);
      rx_v[u]  = 1'b0;
      fall_cyc = cyc;
      repeat (CPB) tick();
      for (int i = 0; i < db_a[u]; i++) drive_bit(u, data[i]);
      if (par_a[u] != PARITY_NONE) drive_bit(u, pbit);
      for (int i = 0; i < sb_a[u]; i++) drive_bit(u, stops[i]);
      rx_v[u] = end_level;
   endtask

   task automatic take_beat(input string tag, input int fall, input logic [8:0] ed,
                            input logic [1:0] eu);
      beat_t b;
      check({tag, "_beats"}, beat_q.size(), 1);
      if (beat_q.size() > 0) begin
         b = beat_q.pop_front();
         check({tag, "_unit_data"}, {b.u[3:0], 3'b0, b.data}, {4'(b.u), 3'b0, ed});
         check({tag, "_user"}, b.user, eu);
         check({tag, "_latency"}, b.cyc - fall, lat_exp(b.u));
      end
      beat_q.delete();
   endtask

   task automatic run_frame(input string tag, input int u, input logic [8:0] data,
                            input logic pbit, input logic [1:0] stops,
                            input logic [8:0] ed, input logic [1:0] eu);
      int f;
      beat_q.delete();
      send_frame(u, data, pbit, stops, 1'b1, f);
      repeat (4) tick();
      take_beat(tag, f, ed, eu);
   endtask

   initial begin
      vec_t       vecs [9];
      logic [8:0] ed;
      logic [1:0] eu;
      int         f;
      int         ov0;

      vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 2'b00};
      vecs[1] = '{1, 9'h035, 1'b1, 2'b11, 9'h035, 2'b01};
      vecs[2] = '{1, 9'h035, 1'b0, 2'b11, 9'h035, 2'b00};
      vecs[3] = '{2, 9'h03C, 1'b0, 2'b01, 9'h03C, 2'b10};
      vecs[4] = '{2, 9'h081, 1'b0, 2'b11, 9'h081, 2'b00};
      vecs[5] = '{3, 9'h1FF, 1'b0, 2'b11, 9'h1FF, 2'b00};
      vecs[6] = '{3, 9'h0F3, 1'b0, 2'b11, 9'h0F3, 2'b01};
      vecs[7] = '{0, 9'h000, 1'b0, 2'b10, 9'h000, 2'b10};
      vecs[8] = '{1, 9'h07F, 1'b1, 2'b10, 9'h07F, 2'b10};

      rst_n    = 1'b0;
      rx_v     = 4'hF;
      tready_v = 4'hF;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         check("reset_outputs", {tv_v[i], ov_v[i], tu_v[i], td_v[i]}, 32'h0);
      end
      rst_n = 1'b1;
      repeat (4) tick();

      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].u, vecs[i].data, vecs[i].pbit,
                   vecs[i].stops, vecs[i].exp_data, vecs[i].exp_user);
         repeat (4) tick();
      end

      // Break on 8N2: one error word, then nothing while the line stays low.
      beat_q.delete();
      send_frame(2, 9'h000, 1'b0, 2'b00, 1'b0, f);
      repeat (4) tick();
      take_beat("break", f, 9'h000, 2'b10);
      repeat (12 * CPB) tick();
      check("break_no_retrigger", beat_q.size(), 0);
      rx_v[2] = 1'b1;
      repeat (CPB) tick();
      check("break_release_quiet", beat_q.size(), 0);
      run_frame("after_break", 2, 9'h05A, 1'b0, 2'b11, 9'h05A, 2'b00);

      // Short low glitch is rejected as a false start.
      beat_q.delete();
      rx_v[0] = 1'b0;
      repeat (CPB / 2 - 2) tick();
      rx_v[0] = 1'b1;
      repeat (3 * CPB) tick();
      check("glitch_no_beat", beat_q.size(), 0);
      run_frame("after_glitch", 0, 9'h0C3, 1'b0, 2'b11, 9'h0C3, 2'b00);

      // Overflow: second word replaces the unaccepted first one.
      tready_v[0] = 1'b0;
      ov0 = ov_cnt[0];
      send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1, f);
      repeat (4) tick();
      check("ovf_none_yet", ov_cnt[0] - ov0, 0);
      check("ovf_first_held", {tv_v[0], td_v[0]}, {1'b1, 9'h011});
      send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1, f);
      repeat (4) tick();
      check("ovf_pulses", ov_cnt[0] - ov0, 1);
      check("ovf_held_word", {tv_v[0], tu_v[0], td_v[0]}, {1'b1, 2'b00, 9'h022});
      check("ovf_no_beat", beat_q.size(), 0);
      tready_v[0] = 1'b1;
      repeat (3) tick();
      check("ovf_one_beat", beat_q.size(), 1);
      if (beat_q.size() > 0) check("ovf_beat_data", beat_q[0].data, 9'h022);
      check("ovf_tvalid_drop", tv_v[0], 1'b0);
      beat_q.delete();

      // Reset in the middle of data bit 4 with a word already held.
      tready_v[0] = 1'b0;
      send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1, f);
      repeat (4) tick();
      check("pre_reset_valid", tv_v[0], 1'b1);
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      repeat (CPB / 2) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      check("mid_reset_outputs", {tv_v[0], ov_v[0], tu_v[0], td_v[0]}, 32'h0);
      rst_n       = 1'b1;
      tready_v[0] = 1'b1;
      beat_q.delete();
      repeat (6 * CPB) tick();
      check("post_reset_quiet", beat_q.size(), 0);
      run_frame("post_reset", 0, 9'h03C, 1'b0, 2'b11, 9'h03C, 2'b00);

      // Random frames against the framing-rule model.
      for (int n = 0; n < 40; n++) begin
         int         u;
         logic [8:0] data;
         logic       pbit;
         logic [1:0] stops;
         u     = $urandom_range(0, 3);
         data  = 9'($urandom);
         pbit  = 1'($urandom_range(0, 1));
         stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         model(u, data, pbit, stops, ed, eu);
         run_frame($sformatf("rnd%0d", n), u, data, pbit, stops, ed, eu);
         repeat ($urandom_range(2, 6)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
